// File: rtl/program_memory_if.sv
// Load/read bus of the SAP program memory.
// The CPU/loader side drives the master modport; the RAM is the slave.
interface program_memory_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] i_address;
    logic                  i_enable_out;
    logic                  i_program;
    logic                  i_load_valid;
    logic [DATA_WIDTH-1:0] i_load_data;
    logic                  o_load_ready;
    logic                  o_load_done;
    logic [DATA_WIDTH-1:0] o_data;

    modport master (
        output i_address,
        output i_enable_out,
        output i_program,
        output i_load_valid,
        output i_load_data,
        input  o_load_ready,
        input  o_load_done,
        input  o_data
    );

    modport slave (
        input  i_address,
        input  i_enable_out,
        input  i_program,
        input  i_load_valid,
        input  i_load_data,
        output o_load_ready,
        output o_load_done,
        output o_data
    );
endinterface

// File: rtl/program_memory.sv
// SAP program RAM: registered reads in run mode, streamed
// program load through a valid/ready port in program mode.
module program_memory #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic              i_clock,
    input  logic              i_reset,
    program_memory_if.slave   bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    localparam logic [1:0] RUN  = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [ADDR_WIDTH-1:0] LAST = '1;

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic                  we;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        data_d  = '0;
        we      = 1'b0;
        unique case (state_q)
            RUN: begin
                if (bus.i_program) begin
                    state_d = LOAD;
                    ptr_d   = '0;
                end else if (bus.i_enable_out) begin
                    data_d = mem_q[bus.i_address];
                end
            end
            LOAD: begin
                if (bus.i_load_valid) begin
                    we    = 1'b1;
                    ptr_d = ptr_q + 1'b1;
                    if (ptr_q == LAST) begin
                        state_d = DONE;
                    end
                end
                // abort wins over completion; a same-edge word is still written
                if (!bus.i_program) begin
                    state_d = RUN;
                end
            end
            DONE: begin
                if (!bus.i_program) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q <= RUN;
            ptr_q   <= '0;
            data_q  <= '0;
            mem_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            if (we) begin
                mem_q[ptr_q] <= bus.i_load_data;
            end
        end
    end

    assign bus.o_data       = data_q;
    assign bus.o_load_ready = (state_q == LOAD);
    assign bus.o_load_done  = (state_q == DONE);
endmodule

// File: tb/tb_program_memory.sv
// Scoreboard bench for program_memory: a behavioural model pushes the
// expected per-cycle outputs, a monitor pops and compares them.
module tb_program_memory;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    program_memory_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) bus ();

    program_memory #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       ready;
        logic       done;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: program mode flags, next load slot and the RAM image
    bit         m_loading;
    bit         m_finished;
    int         m_next;
    logic [7:0] m_mem [16];

    always @(posedge clk) begin
        exp_t e;
        e.data = 8'h00;
        if (rst) begin
            m_loading  = 0;
            m_finished = 0;
            m_next     = 0;
            for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
        end else if (m_loading) begin
            if (bus.i_load_valid) begin
                m_mem[m_next] = bus.i_load_data;
                m_next = m_next + 1;
                if (m_next == 16) begin
                    m_loading  = 0;
                    m_finished = 1;
                end
            end
            if (!bus.i_program) begin
                m_loading  = 0;
                m_finished = 0;
            end
        end else if (m_finished) begin
            if (!bus.i_program) m_finished = 0;
        end else begin
            if (bus.i_program) begin
                m_loading = 1;
                m_next    = 0;
            end else if (bus.i_enable_out) begin
                e.data = m_mem[bus.i_address];
            end
        end
        e.ready = m_loading;
        e.done  = m_finished;
        q.push_back(e);
    end

    always begin
        exp_t e;
        @(posedge clk or posedge rst);
        #1;
        if (!clk) begin
            if (rst) begin
                checks++;
                if (bus.o_load_ready !== 1'b0 || bus.o_data !== 8'h00 ||
                    bus.o_load_done !== 1'b0) begin
                    errors++;
                    $display("FAIL async_reset: got data=%h ready=%b done=%b want 00 0 0",
                             bus.o_data, bus.o_load_ready, bus.o_load_done);
                end
            end
        end else if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty at %0t", $time);
        end else begin
            e = q.pop_front();
            checks++;
            if (bus.o_data !== e.data || bus.o_load_ready !== e.ready ||
                bus.o_load_done !== e.done) begin
                errors++;
                $display("FAIL cycle@%0t: got data=%h ready=%b done=%b want data=%h ready=%b done=%b",
                         $time, bus.o_data, bus.o_load_ready, bus.o_load_done,
                         e.data, e.ready, e.done);
            end
        end
    end

    task automatic rd(input logic [3:0] a, input logic en);
        bus.i_address    = a;
        bus.i_enable_out = en;
        @(negedge clk);
    endtask

    // vmode: 0 continuous valid, 1 alternating, 2 random gaps
    task automatic load(input logic [7:0] base, input int beats,
                        input int vmode, input bit abort_same);
        int i;
        int cyc;
        bus.i_enable_out = 1'b0;
        bus.i_program    = 1'b1;
        bus.i_load_valid = 1'b0;
        @(negedge clk);
        i   = 0;
        cyc = 0;
        while (i < beats) begin
            if ((vmode == 1 && cyc[0] == 1'b0) ||
                (vmode == 2 && $urandom_range(1) == 0)) begin
                bus.i_load_valid = 1'b0;
                bus.i_load_data  = 8'($urandom);
            end else begin
                bus.i_load_valid = 1'b1;
                bus.i_load_data  = base + 8'(i);
                i++;
                if (abort_same && i == beats && beats < 16)
                    bus.i_program = 1'b0;
            end
            cyc++;
            @(negedge clk);
        end
        bus.i_load_valid = 1'b0;
        if (beats >= 16) begin
            bus.i_load_valid = 1'b1;
            bus.i_load_data  = 8'($urandom);
            repeat (2) @(negedge clk);
            bus.i_load_valid = 1'b0;
        end
        bus.i_program = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        bus.i_address    = '0;
        bus.i_enable_out = 1'b0;
        bus.i_program    = 1'b0;
        bus.i_load_valid = 1'b0;
        bus.i_load_data  = '0;
        rst = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        rd(4'd5, 1'b1);
        rd(4'd5, 1'b1);

        load(8'h10, 16, 0, 0);
        rd(4'd3, 1'b1);
        rd(4'd3, 1'b0);

        load(8'hA0, 16, 1, 0);
        for (int a = 0; a < 16; a++) rd(4'(a), 1'b1);
        rd(4'd15, 1'b1);

        load(8'h10, 16, 0, 0);
        load(8'h50, 5, 0, 0);
        for (int a = 0; a < 7; a++) rd(4'(a), 1'b1);
        load(8'h60, 2, 2, 1);
        for (int a = 0; a < 6; a++) rd(4'(a), 1'b1);

        rd(4'd0, 1'b1);
        rd(4'd1, 1'b1);
        rd(4'd2, 1'b1);
        rd(4'd2, 1'b0);
        rd(4'd1, 1'b1);

        repeat (300) begin
            int pick;
            pick = int'($urandom_range(9));
            if (pick < 8) begin
                rd(4'($urandom), 1'($urandom));
            end else begin
                load(8'($urandom), int'($urandom_range(16, 1)),
                     int'($urandom_range(2)), 1'($urandom));
            end
        end

        // Async reset between edges in the middle of a load
        bus.i_program = 1'b1;
        @(negedge clk);
        bus.i_load_valid = 1'b1;
        bus.i_load_data  = 8'h77;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.i_program    = 1'b0;
        bus.i_load_valid = 1'b0;
        rst = 1'b0;
        for (int a = 0; a < 16; a++) rd(4'(a), 1'b1);
        rd(4'd0, 1'b0);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
